// File: rtl/i2c_xfer_sched.sv
// Round-robin transfer scheduler that shares one byte-command I2C master core
// between NUM_REQ requesters: START, address byte, data bytes, STOP.
module i2c_xfer_sched #(
  parameter int NUM_REQ        = 4,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]            req_rd_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic [I2C_DATA_WIDTH-1:0]     wr_data_i,
  output logic                          wr_pop_o,
  output logic [I2C_DATA_WIDTH-1:0]     rd_data_o,
  output logic                          rd_valid_o,
  output logic                          xfer_done_o,
  output logic                          xfer_err_o,
  output logic                          busy_o,
  output logic [2:0]                    cmd_o,
  output logic [I2C_DATA_WIDTH-1:0]     cmd_data_o,
  output logic                          cmd_valid_o,
  input  logic                          cmd_done_i,
  input  logic                          cmd_nak_i,
  input  logic [I2C_DATA_WIDTH-1:0]     cmd_rdata_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] CMD_START  = 3'b100;
  localparam logic [2:0] CMD_STOP   = 3'b101;
  localparam logic [2:0] CMD_WRITE  = 3'b001;
  localparam logic [2:0] CMD_RD_ACK = 3'b010;
  localparam logic [2:0] CMD_RD_NAK = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_WDATA, S_RDATA, S_STOP, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [I2C_ADDR_WIDTH-1:0] req_addr [NUM_REQ];
  logic [LEN_WIDTH-1:0]      req_len  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_addr[gi] = req_addr_i[gi*I2C_ADDR_WIDTH +: I2C_ADDR_WIDTH];
      assign req_len[gi]  = req_len_i[gi*LEN_WIDTH +: LEN_WIDTH];
    end
  endgenerate

  logic [NUM_REQ-1:0]        gnt_reg;
  logic [PTR_W-1:0]          rr_ptr_reg;
  logic [I2C_ADDR_WIDTH-1:0] addr_reg;
  logic                      rd_reg;
  logic [LEN_WIDTH-1:0]      cnt_reg;
  logic                      err_reg;
  logic                      gap_reg;
  logic [I2C_DATA_WIDTH-1:0] rd_data_reg;
  logic                      rd_valid_reg;

  logic [PTR_W-1:0] win_idx;
  logic             win_found;
  logic             in_cmd_state;
  logic             cmd_act;
  logic             cmd_fire;

  // Search starts at the round-robin pointer and wraps past the top requester.
  always_comb begin
    int idx;
    idx       = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req_i[PTR_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  assign in_cmd_state = (state_reg == S_START) || (state_reg == S_ADDR) ||
                        (state_reg == S_WDATA) || (state_reg == S_RDATA) ||
                        (state_reg == S_STOP);
  // gap_reg forces one idle cycle on cmd_valid_o after every accepted command.
  assign cmd_act  = in_cmd_state && !gap_reg;
  assign cmd_fire = cmd_act && cmd_done_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (win_found) state_next = S_START;
      S_START: if (cmd_fire) state_next = S_ADDR;
      S_ADDR: begin
        if (cmd_fire) begin
          if (cmd_nak_i || (cnt_reg == '0)) state_next = S_STOP;
          else if (rd_reg)                  state_next = S_RDATA;
          else                              state_next = S_WDATA;
        end
      end
      S_WDATA: if (cmd_fire && (cmd_nak_i || (cnt_reg == LEN_WIDTH'(1)))) state_next = S_STOP;
      S_RDATA: if (cmd_fire && (cnt_reg == LEN_WIDTH'(1))) state_next = S_STOP;
      S_STOP:  if (cmd_fire) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_reg      <= '0;
      rr_ptr_reg   <= '0;
      addr_reg     <= '0;
      rd_reg       <= 1'b0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      gap_reg      <= 1'b0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      gap_reg      <= cmd_fire;
      rd_valid_reg <= 1'b0;
      if ((state_reg == S_IDLE) && win_found) begin
        gnt_reg    <= NUM_REQ'(1) << win_idx;
        addr_reg   <= req_addr[win_idx];
        rd_reg     <= req_rd_i[win_idx];
        cnt_reg    <= req_len[win_idx];
        err_reg    <= 1'b0;
        rr_ptr_reg <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      if (cmd_fire && ((state_reg == S_WDATA) || (state_reg == S_RDATA)) && (cnt_reg != '0))
        cnt_reg <= cnt_reg - 1'b1;
      if (cmd_fire && cmd_nak_i && ((state_reg == S_ADDR) || (state_reg == S_WDATA)))
        err_reg <= 1'b1;
      if (cmd_fire && (state_reg == S_RDATA)) begin
        rd_valid_reg <= 1'b1;
        rd_data_reg  <= cmd_rdata_i;
      end
      if (state_reg == S_DONE) begin
        gnt_reg <= '0;
        err_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    cmd_o       = '0;
    cmd_data_o  = '0;
    cmd_valid_o = cmd_act;
    wr_pop_o    = 1'b0;
    busy_o      = in_cmd_state;
    gnt_o       = in_cmd_state ? gnt_reg : '0;
    xfer_done_o = 1'b0;
    xfer_err_o  = 1'b0;
    case (state_reg)
      S_START: cmd_o = CMD_START;
      S_ADDR: begin
        cmd_o      = CMD_WRITE;
        cmd_data_o = I2C_DATA_WIDTH'({addr_reg, rd_reg});
      end
      S_WDATA: begin
        cmd_o      = CMD_WRITE;
        cmd_data_o = wr_data_i;
        wr_pop_o   = cmd_fire;
      end
      S_RDATA: cmd_o = (cnt_reg > LEN_WIDTH'(1)) ? CMD_RD_ACK : CMD_RD_NAK;
      S_STOP:  cmd_o = CMD_STOP;
      S_DONE: begin
        xfer_done_o = 1'b1;
        xfer_err_o  = err_reg;
      end
      default: ;
    endcase
  end

  assign rd_data_o  = rd_data_reg;
  assign rd_valid_o = rd_valid_reg;

endmodule

// File: tb/tb_i2c_xfer_sched.sv
// Directed bench for i2c_xfer_sched: a byte-core responder checks each command
// against a queue of expected commands and supplies the ACK/NAK/read data for it.
module tb_i2c_xfer_sched;

  localparam logic [2:0] C_START = 3'b100;
  localparam logic [2:0] C_STOP  = 3'b101;
  localparam logic [2:0] C_WR    = 3'b001;
  localparam logic [2:0] C_RA    = 3'b010;
  localparam logic [2:0] C_RN    = 3'b011;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [27:0] req_addr_i;
  logic [3:0]  req_rd_i;
  logic [31:0] req_len_i;
  logic [3:0]  gnt_o;
  logic [7:0]  wr_data_i;
  logic        wr_pop_o;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;
  logic        xfer_done_o;
  logic        xfer_err_o;
  logic        busy_o;
  logic [2:0]  cmd_o;
  logic [7:0]  cmd_data_o;
  logic        cmd_valid_o;
  logic        cmd_done_i;
  logic        cmd_nak_i;
  logic [7:0]  cmd_rdata_i;

  i2c_xfer_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_addr_i(req_addr_i),
    .req_rd_i(req_rd_i), .req_len_i(req_len_i), .gnt_o(gnt_o),
    .wr_data_i(wr_data_i), .wr_pop_o(wr_pop_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .xfer_done_o(xfer_done_o), .xfer_err_o(xfer_err_o),
    .busy_o(busy_o), .cmd_o(cmd_o), .cmd_data_o(cmd_data_o),
    .cmd_valid_o(cmd_valid_o), .cmd_done_i(cmd_done_i), .cmd_nak_i(cmd_nak_i),
    .cmd_rdata_i(cmd_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] data;
    logic       nak;
    logic [7:0] rdata;
  } exp_cmd_t;

  exp_cmd_t   cmd_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] wd_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [7:0] d, input logic n, input logic [7:0] r);
    exp_cmd_t e;
    e.cmd = c; e.data = d; e.nak = n; e.rdata = r;
    cmd_q.push_back(e);
  endtask

  task automatic set_req(input int k, input logic [6:0] addr, input logic rd, input logic [7:0] len);
    req_addr_i[k*7 +: 7] = addr;
    req_rd_i[k]          = rd;
    req_len_i[k*8 +: 8]  = len;
  endtask

  // Plays the byte core for one transfer; max_cmds > 0 stops after that many commands.
  task automatic service(input string name, input logic [3:0] exp_gnt, input int max_cmds,
                         input logic [3:0] req_after_gnt, input logic [3:0] req_at_done,
                         input logic exp_err, input int exp_pops);
    int cyc = 0, lat = 0, ncmd = 0, pops = 0;
    logic seen_gnt = 1'b0, done_seen = 1'b0, shift_wd = 1'b0, after_fire = 1'b0;
    exp_cmd_t e;
    wr_data_i = (wd_q.size() != 0) ? wd_q[0] : 8'h00;
    while (cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      cmd_done_i = 1'b0;
      cmd_nak_i  = 1'b0;
      if (shift_wd) begin
        void'(wd_q.pop_front());
        wr_data_i = (wd_q.size() != 0) ? wd_q[0] : 8'h00;
        shift_wd  = 1'b0;
      end
      #1;
      if (wr_pop_o) pops++;
      if (after_fire) begin
        chk({name, ":valid_gap"}, cmd_valid_o, 1'b0);
        after_fire = 1'b0;
      end
      if (busy_o) begin
        chk({name, ":gnt"}, gnt_o, exp_gnt);
        if (!seen_gnt) begin
          seen_gnt = 1'b1;
          req_i    = req_after_gnt;
        end
      end
      if (rd_valid_o) begin
        if (rd_q.size() == 0) chk({name, ":rd_valid_extra"}, rd_valid_o, 1'b0);
        else                  chk({name, ":rd_data"}, rd_data_o, rd_q.pop_front());
      end
      if (xfer_done_o) begin
        done_seen = 1'b1;
        chk({name, ":err"}, xfer_err_o, exp_err);
        chk({name, ":pops"}, pops, exp_pops);
        chk({name, ":busy_at_done"}, busy_o, 1'b0);
        chk({name, ":gnt_at_done"}, gnt_o, 4'b0000);
        chk({name, ":cmds_left"}, cmd_q.size(), 0);
        chk({name, ":reads_left"}, rd_q.size(), 0);
        $display("xfer %s gnt=%b err=%0b pops=%0d cycles=%0d", name, exp_gnt, xfer_err_o, pops, cyc);
        req_i = req_at_done;
        break;
      end
      if (cmd_valid_o) begin
        if (lat > 0) lat--;
        else if (cmd_q.size() == 0) begin
          chk({name, ":cmd_extra"}, cmd_valid_o, 1'b0);
          break;
        end else begin
          e = cmd_q.pop_front();
          chk({name, ":cmd"}, cmd_o, e.cmd);
          if (e.cmd == C_WR) chk({name, ":cmd_data"}, cmd_data_o, e.data);
          cmd_done_i  = 1'b1;
          cmd_nak_i   = e.nak;
          cmd_rdata_i = e.rdata;
          #1;
          if (wr_pop_o) begin
            pops++;
            shift_wd = 1'b1;
          end
          after_fire = 1'b1;
          ncmd++;
          lat = int'($urandom_range(0, 2));
          if (max_cmds != 0 && ncmd == max_cmds) break;
        end
      end
    end
    if (max_cmds == 0) chk({name, ":done_seen"}, done_seen, 1'b1);
    else               chk({name, ":cmds_issued"}, ncmd, max_cmds);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, ":gnt"}, gnt_o, 4'b0000);
    chk({name, ":busy"}, busy_o, 1'b0);
    chk({name, ":cmd_valid"}, cmd_valid_o, 1'b0);
    chk({name, ":cmd"}, cmd_o, 3'b000);
    chk({name, ":cmd_data"}, cmd_data_o, 8'h00);
    chk({name, ":wr_pop"}, wr_pop_o, 1'b0);
    chk({name, ":rd_valid"}, rd_valid_o, 1'b0);
    chk({name, ":rd_data"}, rd_data_o, 8'h00);
    chk({name, ":done"}, xfer_done_o, 1'b0);
    chk({name, ":err"}, xfer_err_o, 1'b0);
  endtask

  logic [6:0] rr_addr [4];

  initial begin
    rst_i = 1'b1; req_i = '0; req_addr_i = '0; req_rd_i = '0; req_len_i = '0;
    wr_data_i = '0; cmd_done_i = 1'b0; cmd_nak_i = 1'b0; cmd_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    check_idle_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Two-byte write from requester 0
    set_req(0, 7'h22, 1'b0, 8'd2);
    wd_q = '{8'h5A, 8'hA5};
    push(C_START, 8'h00, 1'b0, 8'h00);
    push(C_WR, 8'h44, 1'b0, 8'h00);
    push(C_WR, 8'h5A, 1'b0, 8'h00);
    push(C_WR, 8'hA5, 1'b0, 8'h00);
    push(C_STOP, 8'h00, 1'b0, 8'h00);
    req_i = 4'b0001;
    service("write2", 4'b0001, 0, 4'b0000, 4'b0000, 1'b0, 2);

    // Three-byte read from requester 1 (pointer now 1)
    set_req(1, 7'h22, 1'b1, 8'd3);
    push(C_START, 8'h00, 1'b0, 8'h00);
    push(C_WR, 8'h45, 1'b0, 8'h00);
    push(C_RA, 8'h00, 1'b0, 8'h10);
    push(C_RA, 8'h00, 1'b0, 8'h11);
    push(C_RN, 8'h00, 1'b0, 8'h12);
    push(C_STOP, 8'h00, 1'b0, 8'h00);
    rd_q = '{8'h10, 8'h11, 8'h12};
    req_i = 4'b0010;
    service("read3", 4'b0010, 0, 4'b0000, 4'b0000, 1'b0, 0);

    // Address NAK on a four-byte write from requester 2
    set_req(2, 7'h50, 1'b0, 8'd4);
    wd_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    push(C_START, 8'h00, 1'b0, 8'h00);
    push(C_WR, 8'hA0, 1'b1, 8'h00);
    push(C_STOP, 8'h00, 1'b0, 8'h00);
    req_i = 4'b0100;
    service("addr_nak", 4'b0100, 0, 4'b0000, 4'b0000, 1'b1, 0);
    chk("addr_nak:wd_unpopped", wd_q.size(), 4);
    wd_q.delete();

    // Zero-length write from requester 3
    set_req(3, 7'h7F, 1'b0, 8'd0);
    push(C_START, 8'h00, 1'b0, 8'h00);
    push(C_WR, 8'hFE, 1'b0, 8'h00);
    push(C_STOP, 8'h00, 1'b0, 8'h00);
    req_i = 4'b1000;
    service("zero_len", 4'b1000, 0, 4'b0000, 4'b0000, 1'b0, 0);

    // Round-robin with all four requesting continuously (pointer back at 0)
    rr_addr = '{7'h10, 7'h21, 7'h32, 7'h43};
    for (int k = 0; k < 4; k++) set_req(k, rr_addr[k], 1'b0, 8'd0);
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push(C_START, 8'h00, 1'b0, 8'h00);
      push(C_WR, {rr_addr[k % 4], 1'b0}, 1'b0, 8'h00);
      push(C_STOP, 8'h00, 1'b0, 8'h00);
      service($sformatf("rr%0d", k), 4'b0001 << (k % 4), 0, 4'b1111,
              (k == 4) ? 4'b0101 : 4'b1111, 1'b0, 0);
    end
    push(C_START, 8'h00, 1'b0, 8'h00);
    push(C_WR, {rr_addr[2], 1'b0}, 1'b0, 8'h00);
    push(C_STOP, 8'h00, 1'b0, 8'h00);
    service("rr_0101", 4'b0100, 0, 4'b0000, 4'b0000, 1'b0, 0);

    // Reset while the second write byte is pending
    set_req(0, 7'h22, 1'b0, 8'd3);
    wd_q = '{8'h5A, 8'hA5, 8'h3C};
    push(C_START, 8'h00, 1'b0, 8'h00);
    push(C_WR, 8'h44, 1'b0, 8'h00);
    push(C_WR, 8'h5A, 1'b0, 8'h00);
    req_i = 4'b0001;
    service("pre_reset", 4'b0001, 3, 4'b0000, 4'b0000, 1'b0, 1);
    @(negedge clk_i);
    cmd_done_i = 1'b0;
    cmd_nak_i  = 1'b0;
    chk("pre_reset:busy", busy_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check_idle_outputs("mid_reset");
    rst_i = 1'b0;
    cmd_q.delete();
    wd_q.delete();

    // Fresh read after reset: pointer is 0 again, requester 2 wins alone
    set_req(2, 7'h33, 1'b1, 8'd1);
    push(C_START, 8'h00, 1'b0, 8'h00);
    push(C_WR, 8'h67, 1'b0, 8'h00);
    push(C_RN, 8'h00, 1'b0, 8'h99);
    push(C_STOP, 8'h00, 1'b0, 8'h00);
    rd_q = '{8'h99};
    req_i = 4'b0100;
    service("post_reset", 4'b0100, 0, 4'b0000, 4'b0000, 1'b0, 0);

    repeat (2) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
